// File: rtl/cuckoo_pkg.sv
// Shared definitions for the cuckoo-hash key store: sizes, FSM states and the
// table-1 hash.
package cuckoo_pkg;
    localparam int KEY_W     = 32;
    localparam int IDX_W     = 4;
    localparam int DEPTH     = 1 << IDX_W;
    localparam int MAX_KICKS = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        EVICT,
        WAIT_T2,
        FAIL
    } state_t;

    // Table-1 index: low nibble folded with bits [11:8].
    function automatic logic [IDX_W-1:0] h1(input logic [KEY_W-1:0] k);
        return k[IDX_W-1:0] ^ k[8 +: IDX_W];
    endfunction
endpackage

// File: rtl/cuckoo_t1_insert_if.sv
// Handshake bundle between the table-1 insert stage and its neighbours
// (key source, table-2 stage, status consumers).
interface cuckoo_t1_insert_if;
    import cuckoo_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [KEY_W-1:0] in_key;
    logic             ev_valid;
    logic             ev_ready;
    logic [KEY_W-1:0] ev_key;
    logic             ret_valid;
    logic             ret_ready;
    logic [KEY_W-1:0] ret_key;
    logic             t2_done;
    logic             done_valid;
    logic             fail_valid;
    logic [KEY_W-1:0] fail_key;
    logic [IDX_W:0]   count;
    logic             busy;

    modport slave (
        input  in_valid, in_key, ev_ready, ret_valid, ret_key, t2_done,
        output in_ready, ev_valid, ev_key, ret_ready, done_valid,
               fail_valid, fail_key, count, busy
    );

    modport master (
        output in_valid, in_key, ev_ready, ret_valid, ret_key, t2_done,
        input  in_ready, ev_valid, ev_key, ret_ready, done_valid,
               fail_valid, fail_key, count, busy
    );
endinterface

// File: rtl/cuckoo_t1_table.sv
// Table-1 storage: DEPTH keys with per-entry valid bits, combinational read,
// synchronous write, valid bits cleared asynchronously on rst.
module cuckoo_t1_table
    import cuckoo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [KEY_W-1:0] rd_key,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [KEY_W-1:0] wr_key
);
    logic [KEY_W-1:0] keys [DEPTH];
    logic [DEPTH-1:0] valid;

    assign rd_valid = valid[rd_idx];
    assign rd_key   = keys[rd_idx];

    // Key storage carries no reset; an entry is meaningful only while its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            keys[wr_idx] <= wr_key;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end
endmodule

// File: rtl/cuckoo_t1_insert.sv
// Table-1 insertion stage: places keys at h1(key), evicts occupants to table 2
// and re-inserts bounced keys until the chain settles or runs out of kicks.
module cuckoo_t1_insert #(
    parameter int MAX_KICKS = cuckoo_pkg::MAX_KICKS
) (
    input logic                clk,
    input logic                rst,
    cuckoo_t1_insert_if.slave  bus
);
    import cuckoo_pkg::*;

    localparam int KW = $clog2(MAX_KICKS + 1);

    state_t           state;
    logic [KEY_W-1:0] cur_key;
    logic [KW-1:0]    kicks;
    logic [IDX_W-1:0] slot;
    logic             rd_valid;
    logic [KEY_W-1:0] rd_key;
    logic             hit_empty;
    logic             hit_dup;
    logic             can_kick;
    logic             wr_en;
    logic             accept;
    logic             take_ret;

    assign slot      = h1(cur_key);
    assign hit_empty = !rd_valid;
    assign hit_dup   = rd_valid && (rd_key == cur_key);
    assign can_kick  = kicks < KW'(MAX_KICKS);
    assign wr_en     = (state == LOOKUP) && (hit_empty || (!hit_dup && can_kick));
    assign accept    = (state == IDLE) && bus.in_valid && bus.in_ready;
    assign take_ret  = (state == WAIT_T2) && bus.ret_valid;

    cuckoo_t1_table u_table (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (slot),
        .rd_valid (rd_valid),
        .rd_key   (rd_key),
        .wr_en    (wr_en),
        .wr_idx   (slot),
        .wr_key   (cur_key)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            cur_key <= bus.in_key;
        end else if (take_ret) begin
            cur_key <= bus.ret_key;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            kicks          <= '0;
            bus.in_ready   <= 1'b0;
            bus.ev_valid   <= 1'b0;
            bus.ev_key     <= '0;
            bus.ret_ready  <= 1'b0;
            bus.done_valid <= 1'b0;
            bus.fail_valid <= 1'b0;
            bus.fail_key   <= '0;
            bus.count      <= '0;
            bus.busy       <= 1'b0;
        end else begin
            bus.done_valid <= 1'b0;
            bus.fail_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        kicks        <= '0;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= LOOKUP;
                    end else begin
                        bus.in_ready <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (hit_empty || hit_dup) begin
                        if (hit_empty && (bus.count < (IDX_W+1)'(DEPTH))) begin
                            bus.count <= bus.count + 1'b1;
                        end
                        bus.done_valid <= 1'b1;
                        bus.in_ready   <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                    end else if (can_kick) begin
                        bus.ev_key   <= rd_key;
                        bus.ev_valid <= 1'b1;
                        kicks        <= kicks + KW'(1);
                        state        <= EVICT;
                    end else begin
                        bus.fail_key   <= cur_key;
                        bus.fail_valid <= 1'b1;
                        state          <= FAIL;
                    end
                end
                EVICT: begin
                    if (bus.ev_ready) begin
                        bus.ev_valid  <= 1'b0;
                        bus.ret_ready <= 1'b1;
                        state         <= WAIT_T2;
                    end
                end
                WAIT_T2: begin
                    // A bounce takes priority over a simultaneous t2_done.
                    if (bus.ret_valid) begin
                        bus.ret_ready <= 1'b0;
                        state         <= LOOKUP;
                    end else if (bus.t2_done) begin
                        bus.ret_ready  <= 1'b0;
                        bus.done_valid <= 1'b1;
                        bus.in_ready   <= 1'b1;
                        bus.busy       <= 1'b0;
                        state          <= IDLE;
                    end
                end
                FAIL: begin
                    bus.in_ready <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cuckoo_t1_insert.sv
// Directed bench for the table-1 insertion stage, built with MAX_KICKS=2 so the
// kick limit is reachable with a short chain.
module tb_cuckoo_t1_insert;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    cuckoo_t1_insert_if bus ();

    cuckoo_t1_insert #(.MAX_KICKS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] key;
        int          slot;
        int          count;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] slot_key(input int idx);
        return dut.u_table.keys[idx];
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", bus.in_ready, 1);
    endtask

    // Empty-slot or duplicate insert: expects completion at N+2 without eviction.
    task automatic do_insert(input string nm, input logic [31:0] key, input int slot, input int cnt);
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_key   = key;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check({nm, "_busy_n1"}, bus.busy, 1);
        check({nm, "_done_n1"}, bus.done_valid, 0);
        @(negedge clk);
        check({nm, "_done_n2"}, bus.done_valid, 1);
        check({nm, "_ev_n2"}, bus.ev_valid, 0);
        check({nm, "_count"}, bus.count, cnt);
        check({nm, "_ready_n2"}, bus.in_ready, 1);
        check({nm, "_slot"}, slot_key(slot), key);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100,  1, 2};
        vecs[1] = '{32'h0000_0A03,  9, 3};
        vecs[2] = '{32'hFFFF_F0F0,  0, 4};
        vecs[3] = '{32'h0000_0100,  1, 4};
        vecs[4] = '{32'h0000_0C0F,  3, 5};
        vecs[5] = '{32'h0000_000E, 14, 6};
        vecs[6] = '{32'h0000_0005,  5, 6};

        bus.in_valid  = 1'b0;
        bus.in_key    = '0;
        bus.ev_ready  = 1'b0;
        bus.ret_valid = 1'b0;
        bus.ret_key   = '0;
        bus.t2_done   = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_ev_valid", bus.ev_valid, 0);
        check("rst_ret_ready", bus.ret_ready, 0);
        check("rst_done", bus.done_valid, 0);
        check("rst_fail", bus.fail_valid, 0);
        check("rst_ev_key", bus.ev_key, 0);
        check("rst_fail_key", bus.fail_key, 0);
        check("rst_count", bus.count, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", bus.in_ready, 1);

        do_insert("ins5", 32'h5, 5, 1);

        // Collision with a stalled table-2 stage
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_key   = 32'h15;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("col_ev_n1", bus.ev_valid, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("col_ev_valid", bus.ev_valid, 1);
            check("col_ev_key", bus.ev_key, 32'h5);
        end
        check("col_slot", slot_key(5), 32'h15);
        check("col_count", bus.count, 1);
        bus.ev_ready = 1'b1;
        @(negedge clk);
        bus.ev_ready = 1'b0;
        check("col_wait_ret_ready", bus.ret_ready, 1);
        check("col_wait_ev_low", bus.ev_valid, 0);

        // New key held during WAIT_T2 must wait for completion
        bus.in_valid = 1'b1;
        bus.in_key   = 32'h21;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("hold_in_ready", bus.in_ready, 0);
        end
        bus.t2_done = 1'b1;
        @(negedge clk);
        bus.t2_done = 1'b0;
        check("col_done", bus.done_valid, 1);
        check("col_done_count", bus.count, 1);
        check("col_done_ready", bus.in_ready, 1);
        check("col_done_ret_ready", bus.ret_ready, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("hold_accepted_busy", bus.busy, 1);
        @(negedge clk);
        check("hold_done", bus.done_valid, 1);
        check("hold_count", bus.count, 2);
        check("hold_slot", slot_key(1), 32'h21);

        do_insert("dup15", 32'h15, 5, 2);

        // Kick limit: 0x25 -> evicts 0x15, 0x15 back -> evicts 0x25, 0x25 back -> fail
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_key   = 32'h25;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.ev_ready = 1'b1;
        @(negedge clk);
        check("kick1_ev_valid", bus.ev_valid, 1);
        check("kick1_ev_key", bus.ev_key, 32'h15);
        @(negedge clk);
        check("kick1_ret_ready", bus.ret_ready, 1);
        bus.ret_valid = 1'b1;
        bus.ret_key   = 32'h15;
        @(negedge clk);
        bus.ret_valid = 1'b0;
        check("kick2_ret_ready_low", bus.ret_ready, 0);
        @(negedge clk);
        check("kick2_ev_valid", bus.ev_valid, 1);
        check("kick2_ev_key", bus.ev_key, 32'h25);
        check("kick2_slot", slot_key(5), 32'h15);
        @(negedge clk);
        check("kick2_ret_ready", bus.ret_ready, 1);
        bus.ret_valid = 1'b1;
        bus.ret_key   = 32'h25;
        @(negedge clk);
        bus.ret_valid = 1'b0;
        bus.ev_ready  = 1'b0;
        check("kick3_no_fail_yet", bus.fail_valid, 0);
        @(negedge clk);
        check("fail_valid", bus.fail_valid, 1);
        check("fail_key", bus.fail_key, 32'h25);
        check("fail_no_ev", bus.ev_valid, 0);
        check("fail_slot", slot_key(5), 32'h15);
        check("fail_no_done", bus.done_valid, 0);
        @(negedge clk);
        check("fail_pulse_end", bus.fail_valid, 0);
        check("fail_idle_ready", bus.in_ready, 1);
        check("fail_idle_busy", bus.busy, 0);
        check("fail_count", bus.count, 2);

        // Reset asserted while an eviction is pending
        bus.in_valid = 1'b1;
        bus.in_key   = 32'h35;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_ev_valid", bus.ev_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_ev_valid", bus.ev_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        check("mid_rst_no_done", bus.done_valid, 0);
        check("mid_rst_no_fail", bus.fail_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        do_insert("post_rst5", 32'h5, 5, 1);

        // Table-driven non-colliding and duplicate inserts
        for (int i = 0; i < 7; i++) begin
            do_insert($sformatf("vec%0d", i), vecs[i].key, vecs[i].slot, vecs[i].count);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end
endmodule
